cntr_snap_fifo: RTL

Snapshot buffer placed directly downstream of the counter block. It captures the 32-bit count value `cnt_out_sig` whenever the snapshot strobe is high. Captured values are queued in a small FIFO and presented to a consumer over a valid/ready handshake. The block also reports fill level and a sticky overflow flag so software or a checker can read count timestamps without losing ordering.

---
 rtl/cntr_snap_fifo_if.sv | 25 ++
 rtl/cntr_snap_fifo.sv | 81 ++++++++
 2 files changed

// File: rtl/cntr_snap_fifo_if.sv
// Snapshot FIFO bus: capture side (count + strobe), consumer handshake, status.
interface cntr_snap_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  logic [31:0]              cnt_in_sig;
  logic                     snap_sig;
  logic [31:0]              out_data_sig;
  logic                     out_valid_sig;
  logic                     out_ready_sig;
  logic                     full_sig;
  logic                     empty_sig;
  logic [$clog2(DEPTH):0]   level_sig;
  logic                     ovf_sig;
  logic                     ovf_clr_sig;

  modport master (
    output cnt_in_sig, snap_sig, out_ready_sig, ovf_clr_sig,
    input  out_data_sig, out_valid_sig, full_sig, empty_sig, level_sig, ovf_sig
  );

  modport slave (
    input  cnt_in_sig, snap_sig, out_ready_sig, ovf_clr_sig,
    output out_data_sig, out_valid_sig, full_sig, empty_sig, level_sig, ovf_sig
  );
endinterface

// File: rtl/cntr_snap_fifo.sv
// Count snapshot FIFO with level, full/empty and sticky overflow status.
// Define CNTR_SNAP_DELTA_EN to store deltas from the previous accepted snapshot.
module cntr_snap_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  cntr_snap_fifo_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_word;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && bus.out_ready_sig;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = bus.snap_sig && (!w_full || w_pop);
  assign w_drop  = bus.snap_sig && w_full && !w_pop;

`ifdef CNTR_SNAP_DELTA_EN
  logic [31:0] r_base;

  assign w_word = bus.cnt_in_sig - r_base;

  always_ff @(posedge clk) begin
    if (rst)
      r_base <= '0;
    else if (w_push)
      r_base <= bus.cnt_in_sig;
  end
`else
  assign w_word = bus.cnt_in_sig;
`endif

  always_ff @(posedge clk) begin
    if (!rst && w_push)
      r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (w_pop && !w_push)
        r_level <= r_level - LW'(1);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (bus.ovf_clr_sig)
        r_ovf <= 1'b0;
    end
  end

  assign bus.out_data_sig  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.out_valid_sig = !w_empty;
  assign bus.full_sig      = w_full;
  assign bus.empty_sig     = w_empty;
  assign bus.level_sig     = r_level;
  assign bus.ovf_sig       = r_ovf;
endmodule
